sram_uart_interface: RTL and testbench
======================================

Name: sram_uart_interface

Overview:
- Transmit-side companion to the UART-to-SRAM loader.
- Reads 16-bit words from SRAM over a contiguous address range, high byte first then low byte, and serializes each byte onto a UART TX line as 8N1.
- Sits between the SRAM controller port and the board UART TX pin.
- Used to dump SRAM contents back to the host.

Parameters:
- CLOCK_FREQ, 50000000, Clock frequency in Hz.
- BAUD_RATE, 115200, line rate. BAUD_DIV = CLOCK_FREQ/BAUD_RATE, integer-truncated (434 at the defaults).
- SRAM_READ_LATENCY, 2, cycles from SRAM_address valid to SRAM_read_data valid.

Ports:
- Clock  in  1  system clock.
- Resetn  in  1  asynchronous, active-low reset.
- Initialize  in  1  synchronous abort/clear; has priority over everything except Resetn.
- Enable  in  1  start pulse, sampled only in S_ST_IDLE.
- Start_address  in  18  first word address, sampled on accepted Enable.
- End_address  in  18  last word address (inclusive), sampled on accepted Enable.
- SRAM_address  out  18  read address.
- SRAM_read_data  in  16  read data.
- SRAM_we_n  out  1  tied 1; this block never writes.
- UART_TX_O  out  1  serial line, idle high.
- Busy  out  1  high from accepted Enable until Done asserts.
- Done  out  1  level; set at end of range; cleared on next accepted Enable or on Initialize.

Behaviour:
Reset values:
- SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0, state S_ST_IDLE.

Frame format:
- Start bit 0, data bits LSB first, stop bit 1.
- Each bit is held exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
- UART_TX_O is registered.

States:
- S_ST_IDLE: on Enable, latch the addresses, set SRAM_address=Start_address, Busy=1, Done=0.
  - If End_address < Start_address: go to S_ST_FINISH without reading or transmitting.
  - Otherwise go to S_ST_READ.
- S_ST_READ: count SRAM_READ_LATENCY cycles, then capture SRAM_read_data into a 16-bit word register and go to S_ST_SEND_HIGH.
- S_ST_SEND_HIGH: pulse tx_start for 1 cycle with word[15:8], then go to S_ST_WAIT_HIGH.
- S_ST_WAIT_HIGH: wait until tx_busy=0, then go to S_ST_SEND_LOW.
- S_ST_SEND_LOW / S_ST_WAIT_LOW: same as the high-byte pair, using word[7:0].
- S_ST_NEXT:
  - If SRAM_address == latched end: go to S_ST_FINISH.
  - Else increment SRAM_address and go to S_ST_READ.
- S_ST_FINISH: Busy=0, Done=1, go to S_ST_IDLE.

Timing and range rules:
- The first start-bit edge appears at most SRAM_READ_LATENCY+3 cycles after Enable.
- Byte-to-byte gap is at most 3 idle-high cycles beyond the stop bit.
- End_address=18'h3FFFF is legal. Termination is by equality, so no increment past it and no wrap to 0.
- Start==End sends exactly 2 bytes.
- The address increment is 18-bit; equality is checked before incrementing.

Control edge cases:
- Enable while Busy is ignored. Enable and Initialize in the same cycle: Initialize wins.
- Initialize at any time, including mid-frame:
  - next cycle UART_TX_O=1, state S_ST_IDLE, Busy=0, Done=0, SRAM_address=0;
  - the transmitter's bit and baud counters are cleared.
- The SRAM_read_data capture register is internal and not exposed.

Decomposition:
- Shared package (the existing state-type header): add the enum type SRAM_UART_state_type with the S_ST_* states above.
- Transmitter sub-state is local to the sub-module.
- One sub-module, uart_transmit_controller.
  - Ports: Clock, Resetn, Clear, Start, TX_data[7:0], Busy, UART_TX_O.
  - Parameter BAUD_DIV.
  - Holds the baud counter, 4-bit bit index and shift register.
  - Start is accepted only when Busy=0; Busy rises the cycle after Start.
  - Busy=1 for the whole frame including the stop bit.

Test Plan (defaults: BAUD_DIV=434, latency 2):
- Single word: SRAM[0x00010]=16'hA55A; Start=End=0x10; pulse Enable.
  - Line shows frame A5 (bits 0,1,0,1,0,0,1,0,1,1) then frame 5A.
  - Each bit lasts 434 cycles.
  - Done rises after about 8680 + small overhead cycles; exactly 2 frames are sent.
- Range: SRAM[0..3]=16'h0102, 16'h0304, 16'h0506, 16'h0708; Start=0, End=3.
  - Decoded byte stream is 01 02 03 04 05 06 07 08.
  - SRAM_address ends at 3; SRAM_we_n stays 1 throughout.
- Top boundary: Start=End=0x3FFFF with data 16'hFFEE.
  - Bytes FF EE are sent, SRAM_address stays 0x3FFFF, no wrap, Done=1.
- Empty range: Start=5, End=4.
  - No start bit ever; Done=1 within 3 cycles; Busy pulses to 0.
- Abort: assert Initialize at bit 4 of the first frame.
  - UART_TX_O=1 next cycle, Busy=0, Done=0, SRAM_address=0.
  - A fresh Enable then produces a complete, correct transfer.
- Reset mid-transfer: drop Resetn asynchronously mid-frame.
  - Outputs take reset values immediately, without waiting for a clock edge.
  - Enable while Busy (retrigger during frame 1) has no effect on the address or byte sequence.

Source files
------------

// File: rtl/sram_uart_interface_pkg.sv
// Shared types and constants for the SRAM-to-UART dump path.
package sram_uart_interface_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_ST_IDLE,
        S_ST_READ,
        S_ST_SEND_HIGH,
        S_ST_WAIT_HIGH,
        S_ST_SEND_LOW,
        S_ST_WAIT_LOW,
        S_ST_NEXT,
        S_ST_FINISH
    } SRAM_UART_state_type;

    // Integer-truncated clock cycles per serial bit.
    function automatic int calc_baud_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sram_uart_interface_if.sv
// Control, SRAM read port and serial line of the dump engine; master is the
// surrounding system, slave is the dump engine itself.
interface sram_uart_interface_if;
    import sram_uart_interface_pkg::*;

    logic              Initialize;
    logic              Enable;
    logic [ADDR_W-1:0] Start_address;
    logic [ADDR_W-1:0] End_address;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_read_data;
    logic              SRAM_we_n;
    logic              UART_TX_O;
    logic              Busy;
    logic              Done;

    modport master (
        output Initialize, Enable, Start_address, End_address, SRAM_read_data,
        input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );

    modport slave (
        input  Initialize, Enable, Start_address, End_address, SRAM_read_data,
        output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );

endinterface

// File: rtl/sram_uart_interface_uart_transmit_controller.sv
// 8N1 serializer: one byte per Start pulse, each bit held BAUD_DIV cycles.
module uart_transmit_controller #(
    parameter int BAUD_DIV = 434
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Clear,
    input  logic       Start,
    input  logic [7:0] TX_data,
    output logic       Busy,
    output logic       UART_TX_O
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [8:0]       shift_reg;
    logic             busy_reg;
    logic             tx_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (Clear) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            busy_reg     <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (!busy_reg) begin
            if (Start) begin
                // Start bit goes out now; the stop bit rides in at the top of the shifter.
                busy_reg     <= 1'b1;
                tx_reg       <= 1'b0;
                shift_reg    <= {1'b1, TX_data};
                baud_cnt_reg <= '0;
                bit_idx_reg  <= '0;
            end
        end else if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 4'd9) begin
                busy_reg    <= 1'b0;
                tx_reg      <= 1'b1;
                bit_idx_reg <= '0;
            end else begin
                tx_reg      <= shift_reg[0];
                shift_reg   <= {1'b1, shift_reg[8:1]};
                bit_idx_reg <= bit_idx_reg + 4'd1;
            end
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    assign Busy      = busy_reg;
    assign UART_TX_O = tx_reg;

endmodule

// File: rtl/sram_uart_interface.sv
// Dumps an inclusive SRAM word range to the UART TX line, high byte first.
module sram_uart_interface
    import sram_uart_interface_pkg::*;
#(
    parameter int CLOCK_FREQ        = 50000000,
    parameter int BAUD_RATE         = 115200,
    parameter int SRAM_READ_LATENCY = 2
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    sram_uart_interface_if.slave bus
);

    localparam int BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam logic [7:0] LAT_LAST = 8'(SRAM_READ_LATENCY);

    SRAM_UART_state_type state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   end_reg;
    logic [DATA_W-1:0]   word_reg;
    logic [7:0]          lat_cnt_reg;
    logic                tx_start_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                tx_busy;
    logic [7:0]          tx_data;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg    <= S_ST_IDLE;
            addr_reg     <= '0;
            end_reg      <= '0;
            word_reg     <= '0;
            lat_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (bus.Initialize) begin
            state_reg    <= S_ST_IDLE;
            addr_reg     <= '0;
            lat_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_ST_IDLE: begin
                    if (bus.Enable) begin
                        addr_reg    <= bus.Start_address;
                        end_reg     <= bus.End_address;
                        lat_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        done_reg    <= 1'b0;
                        state_reg   <= (bus.End_address < bus.Start_address) ? S_ST_FINISH : S_ST_READ;
                    end
                end
                S_ST_READ: begin
                    if (lat_cnt_reg == LAT_LAST) begin
                        word_reg     <= bus.SRAM_read_data;
                        tx_start_reg <= 1'b1;
                        state_reg    <= S_ST_SEND_HIGH;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 8'd1;
                    end
                end
                S_ST_SEND_HIGH: begin
                    tx_start_reg <= 1'b0;
                    state_reg    <= S_ST_WAIT_HIGH;
                end
                S_ST_WAIT_HIGH: begin
                    if (!tx_busy) begin
                        tx_start_reg <= 1'b1;
                        state_reg    <= S_ST_SEND_LOW;
                    end
                end
                S_ST_SEND_LOW: begin
                    tx_start_reg <= 1'b0;
                    state_reg    <= S_ST_WAIT_LOW;
                end
                S_ST_WAIT_LOW: begin
                    if (!tx_busy) begin
                        state_reg <= S_ST_NEXT;
                    end
                end
                S_ST_NEXT: begin
                    // Equality before increment: an end of 3FFFF never wraps to 0.
                    if (addr_reg == end_reg) begin
                        state_reg <= S_ST_FINISH;
                    end else begin
                        addr_reg    <= addr_reg + 18'd1;
                        lat_cnt_reg <= '0;
                        state_reg   <= S_ST_READ;
                    end
                end
                S_ST_FINISH: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_ST_IDLE;
                end
                default: state_reg <= S_ST_IDLE;
            endcase
        end
    end

    assign tx_data = (state_reg == S_ST_SEND_HIGH) ? word_reg[15:8] : word_reg[7:0];

    uart_transmit_controller #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Clear     (bus.Initialize),
        .Start     (tx_start_reg),
        .TX_data   (tx_data),
        .Busy      (tx_busy),
        .UART_TX_O (bus.UART_TX_O)
    );

    assign bus.SRAM_address = addr_reg;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.Busy         = busy_reg;
    assign bus.Done         = done_reg;

endmodule

// File: tb/tb_sram_uart_interface.sv
// Bench for sram_uart_interface: SRAM model with read latency, UART line
// decoder, and a word-range model of the expected byte stream.
`timescale 1ns/1ps
module tb_sram_uart_interface;
    import sram_uart_interface_pkg::*;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int DIV      = 16;
    localparam int LAT      = 2;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    sram_uart_interface_if bus();

    sram_uart_interface #(
        .CLOCK_FREQ        (CLK_FREQ),
        .BAUD_RATE         (BAUD),
        .SRAM_READ_LATENCY (LAT)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM: data for the address presented at an edge is visible LAT edges later.
    logic [15:0] mem [0:262143];
    logic [15:0] rd_pipe [0:LAT-1];
    always @(posedge Clock) begin
        rd_pipe[0] <= mem[bus.SRAM_address];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.SRAM_read_data = rd_pipe[LAT-1];

    // Line decoder: a frame is clean when every bit is flat for DIV cycles,
    // start is 0 and stop is 1. gap = idle cycles before its start bit.
    typedef struct {
        logic [7:0] data;
        bit         clean;
        int         gap;
    } frame_t;
    frame_t rx_q[$];

    logic [9:0] mon_bits;
    logic       mon_cur;
    int         mon_k      = 0;
    bit         mon_active = 1'b0;
    bit         mon_clean  = 1'b1;
    int         mon_gap    = 1000;
    int         we_bad     = 0;

    always @(negedge Clock) begin
        if (bus.SRAM_we_n !== 1'b1) we_bad++;
        if (!Resetn || bus.Initialize) begin
            mon_active = 1'b0;
            mon_gap    = 1000;
        end else begin
            if (!mon_active && bus.UART_TX_O == 1'b0) begin
                mon_active = 1'b1;
                mon_k      = 0;
                mon_clean  = 1'b1;
                mon_bits   = '0;
            end
            if (mon_active) begin
                if (mon_k % DIV == 0) mon_cur = bus.UART_TX_O;
                else if (bus.UART_TX_O !== mon_cur) mon_clean = 1'b0;
                if (mon_k % DIV == DIV/2) mon_bits[mon_k/DIV] = bus.UART_TX_O;
                mon_k++;
                if (mon_k == 10*DIV) begin
                    frame_t f;
                    f.data  = mon_bits[8:1];
                    f.clean = mon_clean && (mon_bits[0] == 1'b0) && (mon_bits[9] == 1'b1);
                    f.gap   = mon_gap;
                    rx_q.push_back(f);
                    mon_active = 1'b0;
                    mon_gap    = 0;
                end
            end else begin
                mon_gap++;
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int max);
        n_checks++;
        if (act > max) begin
            n_fail++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, max);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(bus.SRAM_address), 32'h0);
        check({tag, "_we_n"}, 32'(bus.SRAM_we_n), 32'h1);
        check({tag, "_tx"},   32'(bus.UART_TX_O), 32'h1);
        check({tag, "_busy"}, 32'(bus.Busy), 32'h0);
        check({tag, "_done"}, 32'(bus.Done), 32'h0);
    endtask

    task automatic wait_line_low(input string name);
        int c = 0;
        while (bus.UART_TX_O !== 1'b0 && c < 50) begin
            step();
            c++;
        end
        check_le(name, c, LAT + 3);
    endtask

    // One dump: expected bytes come from walking the word range in the SRAM array.
    task automatic run_transfer(input logic [17:0] s, input logic [17:0] e, input int exp_frames,
                                input logic [17:0] exp_addr, input bit retrig);
        logic [7:0] exp_bytes[$];
        int base, cycles, first_low, budget, got;
        if (e >= s) begin
            for (int a = int'(s); a <= int'(e); a++) begin
                exp_bytes.push_back(mem[a][15:8]);
                exp_bytes.push_back(mem[a][7:0]);
            end
        end
        base = rx_q.size();
        budget = exp_frames * 10 * DIV + 20 * (exp_frames + 1) + 20;
        bus.Start_address = s;
        bus.End_address   = e;
        bus.Enable        = 1'b1;
        step();
        bus.Enable = 1'b0;
        check("busy_after_enable", 32'(bus.Busy), 32'h1);
        check("done_cleared_by_enable", 32'(bus.Done), 32'h0);
        cycles    = 0;
        first_low = -1;
        while (bus.Done !== 1'b1 && cycles < budget) begin
            if (retrig && cycles == 5 * DIV) begin
                bus.Start_address = s + 18'd7;
                bus.End_address   = s + 18'd9;
                bus.Enable        = 1'b1;
            end else begin
                bus.Enable = 1'b0;
            end
            step();
            cycles++;
            if (first_low < 0 && bus.UART_TX_O === 1'b0) first_low = cycles;
        end
        bus.Enable = 1'b0;
        check_le("done_within_budget", cycles, budget - 1);
        if (exp_frames == 0) check_le("empty_done_latency", cycles, 3);
        else check_le("first_start_bit_latency", first_low, LAT + 3);
        step();
        step();
        got = rx_q.size() - base;
        check("frame_count", 32'(got), 32'(exp_frames));
        for (int i = 0; i < exp_bytes.size() && base + i < rx_q.size(); i++) begin
            check($sformatf("byte%0d", i), 32'(rx_q[base+i].data), 32'(exp_bytes[i]));
            check($sformatf("frame%0d_clean", i), 32'(rx_q[base+i].clean), 32'h1);
            if (i % 2 == 1) check_le($sformatf("byte%0d_gap", i), rx_q[base+i].gap, 3);
        end
        check("final_addr", 32'(bus.SRAM_address), 32'(exp_addr));
        check("final_done", 32'(bus.Done), 32'h1);
        check("final_busy", 32'(bus.Busy), 32'h0);
        $display("xfer start=%05h end=%05h frames=%0d/%0d cycles=%0d addr=%05h",
                 s, e, got, exp_frames, cycles, bus.SRAM_address);
    endtask

    typedef struct {
        logic [17:0] s;
        logic [17:0] e;
        int          frames;
        logic [17:0] fin;
        bit          retrig;
    } vec_t;
    vec_t vecs[10];

    initial begin
        bus.Initialize    = 1'b0;
        bus.Enable        = 1'b0;
        bus.Start_address = '0;
        bus.End_address   = '0;

        for (int a = 0; a < 16'h0200; a++) mem[a] = 16'($urandom);
        mem[18'h00010] = 16'hA55A;
        mem[18'h00000] = 16'h0102;
        mem[18'h00001] = 16'h0304;
        mem[18'h00002] = 16'h0506;
        mem[18'h00003] = 16'h0708;
        mem[18'h3FFFD] = 16'($urandom);
        mem[18'h3FFFE] = 16'($urandom);
        mem[18'h3FFFF] = 16'hFFEE;

        vecs[0] = '{18'h00010, 18'h00010, 2, 18'h00010, 1'b0};
        vecs[1] = '{18'h00000, 18'h00003, 8, 18'h00003, 1'b0};
        vecs[2] = '{18'h3FFFF, 18'h3FFFF, 2, 18'h3FFFF, 1'b0};
        vecs[3] = '{18'h00005, 18'h00004, 0, 18'h00005, 1'b0};
        vecs[4] = '{18'h00100, 18'h00102, 6, 18'h00102, 1'b1};
        vecs[5] = '{18'h3FFFD, 18'h3FFFF, 6, 18'h3FFFF, 1'b0};
        for (int i = 6; i < 10; i++) begin
            int len;
            len = int'($urandom_range(0, 3));
            vecs[i].s      = 18'($urandom_range(32'h1000, 32'h3F000));
            vecs[i].e      = vecs[i].s + 18'(len);
            vecs[i].frames = 2 * (len + 1);
            vecs[i].fin    = vecs[i].e;
            vecs[i].retrig = 1'b0;
            for (int a = int'(vecs[i].s); a <= int'(vecs[i].e); a++) mem[a] = 16'($urandom);
        end

        repeat (3) step();
        check_idle_outputs("reset");
        Resetn = 1'b1;
        step();
        step();
        check_idle_outputs("post_reset");

        for (int i = 0; i < 10; i++)
            run_transfer(vecs[i].s, vecs[i].e, vecs[i].frames, vecs[i].fin, vecs[i].retrig);

        // Initialize and Enable together: Initialize wins and also clears Done.
        bus.Start_address = 18'h00000;
        bus.End_address   = 18'h00003;
        bus.Enable        = 1'b1;
        bus.Initialize    = 1'b1;
        step();
        bus.Enable     = 1'b0;
        bus.Initialize = 1'b0;
        check_idle_outputs("init_beats_enable");
        begin
            int lows = 0;
            for (int c = 0; c < 2 * LAT + 10; c++) begin
                step();
                if (bus.UART_TX_O !== 1'b1) lows++;
            end
            check("init_beats_enable_no_tx", 32'(lows), 32'h0);
        end

        // Abort at bit 4 of the first frame, then a clean rerun of the same range.
        mem[18'h00020] = 16'hC33C;
        mem[18'h00021] = 16'h1234;
        bus.Start_address = 18'h00020;
        bus.End_address   = 18'h00021;
        bus.Enable        = 1'b1;
        step();
        bus.Enable = 1'b0;
        wait_line_low("abort_first_start_latency");
        repeat (4 * DIV + DIV / 2) step();
        bus.Initialize = 1'b1;
        step();
        bus.Initialize = 1'b0;
        check_idle_outputs("abort");
        run_transfer(18'h00020, 18'h00021, 4, 18'h00021, 1'b0);

        // Asynchronous reset mid-frame: outputs must clear before any clock edge.
        bus.Start_address = 18'h00000;
        bus.End_address   = 18'h00003;
        bus.Enable        = 1'b1;
        step();
        bus.Enable = 1'b0;
        wait_line_low("reset_first_start_latency");
        repeat (2 * DIV + 3) step();
        #2 Resetn = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        step();
        step();
        Resetn = 1'b1;
        step();
        run_transfer(18'h00000, 18'h00003, 8, 18'h00003, 1'b0);

        check("we_n_always_high", 32'(we_bad), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
